// File: rtl/dmux8way16_scatter_pkg.sv
// dmux8way16_scatter_pkg: shared lane geometry and frame state encoding
package dmux8way16_scatter_pkg;
    localparam int DW = 16;
    localparam int NLANES = 8;
    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/dmux8way16_scatter_dmux8way.sv
// dmux8way: decodes a 3-bit lane index and transfer strobe into one-hot lane load enables
module dmux8way
    import dmux8way16_scatter_pkg::*;
(
    input  logic              en,
    input  logic [2:0]        sel,
    output logic [NLANES-1:0] load
);
    always_comb load = en ? ({{(NLANES-1){1'b0}}, 1'b1} << sel) : '0;
endmodule

// File: rtl/dmux8way16_scatter.sv
// dmux8way16_scatter: scatters accepted words into eight lane registers and hands full frames to a consumer
module dmux8way16_scatter
    import dmux8way16_scatter_pkg::*;
#(
    parameter int WIDTH = DW,
    parameter int LANES = NLANES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_addr_mode,
    input  logic [2:0]       in_sel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [LANES-1:0] lane_valid,
    output logic             frame_done,
    input  logic             frame_ack
);
    state_t state_q, state_d;
    logic [2:0] ptr_q, ptr_d, target;
    logic [LANES-1:0] mask_q, mask_d, load;
    logic done_q, done_d, xfer;
    logic [WIDTH-1:0] lane_q [LANES];
    logic [WIDTH-1:0] lane_d [LANES];

    assign in_ready = state_q == FILL;
    assign xfer = in_valid && in_ready;
    assign target = in_addr_mode ? in_sel : ptr_q;

    dmux8way u_dmux (
        .en  (xfer),
        .sel (target),
        .load(load)
    );

    always_comb begin
        state_d = state_q;
        mask_d = mask_q | load;
        ptr_d = (xfer && !in_addr_mode) ? ptr_q + 3'd1 : ptr_q;
        done_d = 1'b0;
        if (state_q == FILL && &mask_d) begin
            state_d = FULL;
            done_d = 1'b1;
        end else if (state_q == FULL && frame_ack) begin
            state_d = FILL;
            mask_d = '0;
            ptr_d = '0;
        end
        for (int i = 0; i < LANES; i++)
            lane_d[i] = load[i] ? in_data : lane_q[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            ptr_q <= '0;
            mask_q <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < LANES; i++)
                lane_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            mask_q <= mask_d;
            done_q <= done_d;
            for (int i = 0; i < LANES; i++)
                lane_q[i] <= lane_d[i];
        end
    end

    assign a = lane_q[0];
    assign b = lane_q[1];
    assign c = lane_q[2];
    assign d = lane_q[3];
    assign e = lane_q[4];
    assign f = lane_q[5];
    assign g = lane_q[6];
    assign h = lane_q[7];
    assign lane_valid = mask_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_dmux8way16_scatter.sv
// tb_dmux8way16_scatter: scoreboard bench with a frame-level reference model
module tb_dmux8way16_scatter;
    logic clk = 1'b0;
    logic reset = 1'b1, in_valid = 1'b0, in_addr_mode = 1'b0, frame_ack = 1'b0;
    logic [15:0] in_data = '0;
    logic [2:0] in_sel = '0;
    logic in_ready, frame_done;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [7:0] lane_valid;

    always #5 clk = ~clk;

    dmux8way16_scatter dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr_mode(in_addr_mode), .in_sel(in_sel),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .lane_valid(lane_valid), .frame_done(frame_done), .frame_ack(frame_ack)
    );

    typedef struct packed {
        logic [7:0][15:0] ln;
        logic [7:0] mask;
        logic rdy;
        logic done;
    } exp_t;

    exp_t q[$];
    exp_t mx;
    int checks = 0, errors = 0;

    logic [7:0][15:0] m_ln = '0;
    logic [7:0] m_mask = '0;
    int m_ptr = 0;
    bit m_full = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input bit v, input logic [15:0] dt, input bit md, input int sl,
                        input bit ack, input bit rs);
        exp_t x;
        int t;
        @(negedge clk);
        reset = rs; in_valid = v; in_data = dt; in_addr_mode = md;
        in_sel = 3'(sl); frame_ack = ack;
        x.done = 1'b0;
        if (rs) begin
            m_ln = '0; m_mask = '0; m_ptr = 0; m_full = 0;
        end else if (!m_full) begin
            if (v) begin
                t = md ? sl : m_ptr;
                m_ln[t] = dt;
                m_mask[t] = 1'b1;
                if (!md) m_ptr = (m_ptr + 1) % 8;
                if (m_mask == 8'hFF) begin
                    m_full = 1;
                    x.done = 1'b1;
                end
            end
        end else if (ack) begin
            m_full = 0; m_mask = '0; m_ptr = 0;
        end
        x.ln = m_ln; x.mask = m_mask; x.rdy = !m_full;
        q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mx = q.pop_front();
            chk("lanes", 128'({h, g, f, e, d, c, b, a}), 128'(mx.ln));
            chk("lane_valid", 128'(lane_valid), 128'(mx.mask));
            chk("in_ready", 128'(in_ready), 128'(mx.rdy));
            chk("frame_done", 128'(frame_done), 128'(mx.done));
        end
    end

    initial begin
        int n;
        step(0, 16'h0, 0, 0, 0, 1);
        step(1, 16'hBEEF, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) step(1, 16'h1000 + 16'(i), 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 5; i++) step(1, 16'hFFFF, 0, 0, 0, 0);
        step(1, 16'hFFFF, 0, 0, 1, 0);
        step(1, 16'h5555, 0, 0, 0, 0);
        step(1, 16'h6666, 0, 0, 1, 0);
        step(0, 16'h0, 0, 0, 0, 1);
        for (int i = 7; i >= 0; i--) step(1, 16'hA000 + 16'(i), 1, i, 0, 0);
        idle(1);
        step(0, 16'h0, 0, 0, 1, 0);
        step(1, 16'h7777, 0, 0, 0, 0);
        step(0, 16'h0, 0, 0, 0, 1);
        step(1, 16'h1111, 1, 3, 0, 0);
        step(1, 16'h2222, 1, 3, 0, 0);
        idle(1);
        step(0, 16'h0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 16'h3000 + 16'(i), 0, 0, 0, 0);
        step(0, 16'h0, 0, 0, 0, 1);
        idle(1);
        step(1, 16'h4444, 0, 0, 0, 0);
        step(0, 16'h0, 0, 0, 0, 1);
        for (int fr = 0; fr < 100; fr++) begin
            n = 0;
            while (!m_full && n < 300) begin
                step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 1) == 1,
                     $urandom_range(0, 7), $urandom_range(0, 7) == 0,
                     $urandom_range(0, 299) == 0);
                n++;
            end
            checks++;
            if (!m_full) begin
                errors++;
                $display("FAIL frame_fill frame %0d: full=%0d required 1", fr, m_full);
            end
            for (int i = 0; i < $urandom_range(0, 3); i++)
                step($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 1) == 1,
                     $urandom_range(0, 7), 0, 0);
            step($urandom_range(0, 1) == 1, 16'($urandom), 0, 0, 1, 0);
        end
        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmux8way16_scatter.md
DMUX8WAY16_SCATTER -- requirements
Module: dmux8way16_scatter

Interface
REQ-001 SHALL have parameters: WIDTH, 16, lane data width; LANES, 8, number of output lanes (fixed at 8; SEL width 3).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  source presents a word.
REQ-005 SHALL have port: in_ready  output  1  block accepts a word this cycle.
REQ-006 SHALL have port: in_data  input  16  word to distribute.
REQ-007 SHALL have port: in_addr_mode  input  1  1 = write lane in_sel; 0 = write lane at the round-robin pointer.
REQ-008 SHALL have port: in_sel  input  3  target lane when in_addr_mode=1.
REQ-009 SHALL have ports: a, b, c, d, e, f, g, h  output  16 each  lane registers 0..7.
REQ-010 SHALL have port: lane_valid  output  8  bit i set when lane i has been written since the last clear.
REQ-011 SHALL have port: frame_done  output  1  one-cycle pulse when lane_valid becomes 8'hFF.
REQ-012 SHALL have port: frame_ack  input  1  consumer releases a full frame.

Function
REQ-013 SHALL accept a word only on the cycle where in_valid && in_ready are both 1 (transfer).
REQ-014 SHALL use two states: FILL (in_ready=1) and FULL (in_ready=0).
REQ-015 SHALL, on a transfer, write in_data into the target lane register at the next rising edge; lane outputs are registered with 1-cycle latency from transfer to output.
REQ-016 SHALL select the target lane as in_sel when in_addr_mode=1, and as the pointer ptr[2:0] otherwise.
REQ-017 SHALL increment ptr modulo 8 (7 wraps to 0) only on round-robin transfers; addressed transfers leave ptr unchanged.
REQ-018 SHALL set lane_valid[target] on every transfer; re-writing an already-valid lane overwrites its data and leaves the mask unchanged.
REQ-019 SHALL go FILL->FULL on the edge where lane_valid becomes 8'hFF, and assert frame_done for exactly that following cycle.
REQ-020 SHALL hold all lane data, lane_valid=8'hFF and in_ready=0 while FULL; in_valid is ignored in FULL.
REQ-021 SHALL, in FULL with frame_ack=1, go to FILL on the next edge, clearing lane_valid to 0 and ptr to 0, while retaining lane data.
REQ-022 SHALL ignore frame_ack in FILL.
REQ-023 SHALL, in the ack cycle, still drive in_ready=0; a word presented in that cycle is not accepted.
REQ-024 SHALL hold all outputs stable when no transfer occurs in FILL.

Reset
REQ-025 SHALL, when reset=1 at a rising edge, set state=FILL, ptr=0, lane_valid=0, frame_done=0 and a..h=16'h0000, regardless of any concurrent transfer or frame_ack.
REQ-026 SHALL drive in_ready=1 in the first cycle after reset is deasserted.
REQ-027 SHALL, on a reset asserted mid-frame, discard the partial frame and produce no frame_done.

Structure
REQ-028 SHALL place WIDTH, LANES and the FILL/FULL state encodings in the shared project include file.
REQ-029 SHALL use exactly one sub-module, dmux8way, which decodes the 3-bit target and the transfer strobe into eight one-hot lane load enables.
REQ-030 SHALL implement lane registers, pointer, mask and state inside dmux8way16_scatter; the module SHALL contain no latches.

Verification
REQ-031 SHALL verify round-robin fill: after reset, 8 round-robin transfers of 16'h1000..16'h1007 -> a..h = 16'h1000..16'h1007; frame_done pulses exactly once, in the cycle after the 8th transfer; in_ready=0.
REQ-032 SHALL verify addressed fill: transfers with sel=7,6,...,0 of 16'hA007..16'hA000 -> lane i = 16'hA00i; ptr remains 0; frame_done after the last transfer.
REQ-033 SHALL verify overwrite: sel=3 written with 16'h1111 then 16'h2222 -> d=16'h2222, lane_valid=8'h08, no frame_done.
REQ-034 SHALL verify hold and ack: in FULL, drive in_valid=1 with 16'hFFFF for 5 cycles -> outputs unchanged; then frame_ack=1 -> next cycle lane_valid=0, in_ready=1; the next round-robin word lands in a.
REQ-035 SHALL verify reset mid-frame: after 3 round-robin transfers, assert reset 1 cycle -> a..h=0, lane_valid=0, ptr=0; no frame_done.
REQ-036 SHALL verify randomized fill: 100 random mixed-mode frames checked against a behavioural model, with cycle-by-cycle comparison of all outputs.
